conv_round_scheduler: RTL and testbench

CONV_ROUND_SCHEDULER -- requirements
Module: conv_round_scheduler

---
 rtl/conv_round_scheduler.sv | 265 ++++++++++++++++++++++++++
 tb/tb_conv_round_scheduler.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_round_scheduler.sv
// -----------------------------------------------------------------------------
// conv_round_scheduler
//
// Sequences one convolution as NUM_ROUND output-row rounds. Each convolution
// enables the memory node once, then every round hands a go token to each of
// the NUM_PE processing elements, waits until every PE has reported its
// round-complete pulse, hands a go token to the adder node and waits for the
// adder to write the row. After the last round a completion token is offered.
//
// Ports
//   clk             single clock, all state changes on its rising edge
//   reset           synchronous, active-high reset
//   start_valid/start_ready     convolution start request (ready only in IDLE)
//   mem_go_valid/mem_go_ready   memory-node enable token, once per convolution
//   pe_go_valid/pe_go_ready     per-PE round-enable tokens [NUM_PE]
//   pe_done         per-PE one-cycle round-complete pulses [NUM_PE]
//   add_go_valid/add_go_ready   adder-node enable token, once per round
//   add_done        one-cycle pulse: adder wrote the row result
//   round_idx       current round, 0..NUM_ROUND-1 (registered)
//   ifmap_base      round_idx*IFMAP_W truncated to ADDR_W (registered)
//   busy            high in every state except IDLE
//   done_valid/done_ready       convolution-complete token
//   timeout         (SCHED_TIMEOUT_EN only) sticky watchdog flag
//
// Optional feature: define SCHED_TIMEOUT_EN to add a watchdog on the two wait
// states. After TIMEOUT_CYC cycles in WAIT_PE or WAIT_ADD the FSM jumps to
// DONE and raises timeout, which stays set until reset or the next start.
// Without the macro the wait states wait indefinitely and the port is absent.
// -----------------------------------------------------------------------------
module conv_round_scheduler #(
  parameter int NUM_PE      = 5,
  parameter int NUM_ROUND   = 3,
  parameter int IFMAP_W     = 7,
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_valid,
  output logic              start_ready,
  output logic              mem_go_valid,
  input  logic              mem_go_ready,
  output logic [NUM_PE-1:0] pe_go_valid,
  input  logic [NUM_PE-1:0] pe_go_ready,
  input  logic [NUM_PE-1:0] pe_done,
  output logic              add_go_valid,
  input  logic              add_go_ready,
  input  logic              add_done,
  output logic [3:0]        round_idx,
  output logic [ADDR_W-1:0] ifmap_base,
  output logic              busy,
  output logic              done_valid,
  input  logic              done_ready
`ifdef SCHED_TIMEOUT_EN
  ,
  output logic              timeout
`endif
);

  // ---------------------------------------------------------------------------
  // Configuration sanity
  // ---------------------------------------------------------------------------
  if (NUM_PE < 1 || NUM_PE > 8 || NUM_ROUND < 1 || NUM_ROUND > 15 ||
      IFMAP_W < 0 || ADDR_W < 1 || TIMEOUT_CYC < 1) begin : g_cfg_check
    $error("conv_round_scheduler: parameter out of range");
  end

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_MEM_GO   = 3'd1;
  localparam logic [2:0] ST_PE_GO    = 3'd2;
  localparam logic [2:0] ST_WAIT_PE  = 3'd3;
  localparam logic [2:0] ST_ADD_GO   = 3'd4;
  localparam logic [2:0] ST_WAIT_ADD = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;

  localparam logic [3:0]        LAST_ROUND = 4'(NUM_ROUND - 1);
  localparam logic [ADDR_W-1:0] BASE_STEP  = ADDR_W'(IFMAP_W);

  logic [2:0]        state_reg, state_next;
  logic [3:0]        round_reg, round_next;
  logic [ADDR_W-1:0] base_reg,  base_next;
  logic [NUM_PE-1:0] accepted_reg, accepted_next;  // PE go tokens taken this round
  logic [NUM_PE-1:0] mask_reg,  mask_next;         // PE done pulses seen this round

  logic              in_pe_go;
  logic              in_wait_pe;
  logic              mask_en;
  logic              mask_full;
  logic              pe_all_acc;
  logic [NUM_PE-1:0] pe_xfer;
  logic              start_xfer;

  assign in_pe_go   = (state_reg == ST_PE_GO);
  assign in_wait_pe = (state_reg == ST_WAIT_PE);
  assign mask_en    = in_pe_go | in_wait_pe;
  assign start_xfer = (state_reg == ST_IDLE) & start_valid;

  // A PE counts as accepted once its token has transferred, either earlier
  // this round or on the current edge.
  assign pe_all_acc = &(accepted_reg | pe_xfer);

  // Pulses arriving on the same edge complete the mask, so the FSM does not
  // lose a cycle when the last PE reports during WAIT_PE.
  assign mask_full  = &(mask_reg | pe_done);

  // ---------------------------------------------------------------------------
  // Per-PE token and done-mask bookkeeping
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PE; gi++) begin : g_pe
      assign pe_go_valid[gi] = in_pe_go & ~accepted_reg[gi];
      assign pe_xfer[gi]     = pe_go_valid[gi] & pe_go_ready[gi];

      // Held only while still in PE_GO; cleared as the FSM leaves so the
      // next round starts with every token outstanding.
      assign accepted_next[gi] = in_pe_go & ~pe_all_acc &
                                 (accepted_reg[gi] | pe_xfer[gi]);

      // OR-accumulate so repeated pulses are harmless; outside PE_GO and
      // WAIT_PE the mask drains to zero, and it is cleared explicitly on the
      // transition to ADD_GO.
      assign mask_next[gi] = mask_en & ~(in_wait_pe & mask_full) &
                             (mask_reg[gi] | pe_done[gi]);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Watchdog (optional)
  // ---------------------------------------------------------------------------
`ifdef SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic             timeout_reg, timeout_next;
  logic             in_wait;
  logic             tmo_hit;
  logic             tmo_fire;
  logic [2:0]       normal_next;

  assign in_wait = in_wait_pe | (state_reg == ST_WAIT_ADD);
  assign tmo_hit = in_wait & (tmo_cnt_reg == TMO_W'(TIMEOUT_CYC - 1));

  // Normal progress out of a wait state wins over a watchdog expiry on the
  // same edge.
  assign tmo_fire = tmo_hit & (normal_next == state_reg);

  // The counter only runs while sitting in a wait state, so it is zero on
  // every entry to WAIT_PE or WAIT_ADD.
  assign tmo_cnt_next = (in_wait && state_next == state_reg) ?
                        tmo_cnt_reg + TMO_W'(1) : '0;

  always_comb begin
    timeout_next = timeout_reg;
    if (start_xfer) begin
      timeout_next = 1'b0;
    end else if (tmo_fire) begin
      timeout_next = 1'b1;
    end
  end

  assign timeout = timeout_reg;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic [2:0] fsm_next;

  always_comb begin
    fsm_next   = state_reg;
    round_next = round_reg;
    base_next  = base_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_valid) begin
          fsm_next   = ST_MEM_GO;
          round_next = 4'd0;
          base_next  = '0;
        end
      end
      ST_MEM_GO: begin
        if (mem_go_ready) fsm_next = ST_PE_GO;
      end
      ST_PE_GO: begin
        if (pe_all_acc) fsm_next = ST_WAIT_PE;
      end
      ST_WAIT_PE: begin
        if (mask_full) fsm_next = ST_ADD_GO;
      end
      ST_ADD_GO: begin
        if (add_go_ready) fsm_next = ST_WAIT_ADD;
      end
      ST_WAIT_ADD: begin
        if (add_done) begin
          if (round_reg == LAST_ROUND) begin
            fsm_next = ST_DONE;
          end else begin
            fsm_next   = ST_PE_GO;
            round_next = round_reg + 4'd1;
            // Running sum equals round_idx*IFMAP_W modulo 2**ADDR_W.
            base_next  = base_reg + BASE_STEP;
          end
        end
      end
      ST_DONE: begin
        if (done_ready) fsm_next = ST_IDLE;
      end
      default: fsm_next = ST_IDLE;
    endcase
  end

`ifdef SCHED_TIMEOUT_EN
  assign normal_next = fsm_next;
  assign state_next  = tmo_fire ? ST_DONE : fsm_next;
`else
  assign state_next  = fsm_next;
`endif

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      round_reg    <= 4'd0;
      base_reg     <= '0;
      accepted_reg <= '0;
      mask_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      round_reg    <= round_next;
      base_reg     <= base_next;
      accepted_reg <= accepted_next;
      mask_reg     <= mask_next;
    end
  end

`ifdef SCHED_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_reg <= '0;
      timeout_reg <= 1'b0;
    end else begin
      tmo_cnt_reg <= tmo_cnt_next;
      timeout_reg <= timeout_next;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs: all decoded from registered state, none depend on inputs
  // ---------------------------------------------------------------------------
  assign start_ready  = (state_reg == ST_IDLE);
  assign busy         = (state_reg != ST_IDLE);
  assign mem_go_valid = (state_reg == ST_MEM_GO);
  assign add_go_valid = (state_reg == ST_ADD_GO);
  assign done_valid   = (state_reg == ST_DONE);
  assign round_idx    = round_reg;
  assign ifmap_base   = base_reg;

endmodule

// File: tb/tb_conv_round_scheduler.sv
// -----------------------------------------------------------------------------
// tb_conv_round_scheduler
//
// Self-checking bench for conv_round_scheduler. A per-cycle vector table
// covers the all-ready timing run; hand-written sequences cover PE
// back-pressure, done-mask accumulation, busy-time starts, reset abort and
// (with SCHED_TIMEOUT_EN) the watchdog. Every add_go and done_valid transfer
// is popped from a scoreboard queue filled when a start is issued.
// -----------------------------------------------------------------------------
module tb_conv_round_scheduler;

  localparam int NUM_PE    = 5;
  localparam int NUM_ROUND = 3;
  localparam int IFMAP_W   = 7;
  localparam int ADDR_W    = 8;
`ifdef SCHED_TIMEOUT_EN
  localparam int TMO       = 20;
`else
  localparam int TMO       = 1000;
`endif

  logic              clk;
  logic              reset;
  logic              start_valid, start_ready;
  logic              mem_go_valid, mem_go_ready;
  logic [NUM_PE-1:0] pe_go_valid, pe_go_ready, pe_done;
  logic              add_go_valid, add_go_ready, add_done;
  logic [3:0]        round_idx;
  logic [ADDR_W-1:0] ifmap_base;
  logic              busy;
  logic              done_valid, done_ready;
`ifdef SCHED_TIMEOUT_EN
  logic              timeout;
`endif

  conv_round_scheduler #(
    .NUM_PE(NUM_PE), .NUM_ROUND(NUM_ROUND), .IFMAP_W(IFMAP_W),
    .ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .start_valid(start_valid), .start_ready(start_ready),
    .mem_go_valid(mem_go_valid), .mem_go_ready(mem_go_ready),
    .pe_go_valid(pe_go_valid), .pe_go_ready(pe_go_ready), .pe_done(pe_done),
    .add_go_valid(add_go_valid), .add_go_ready(add_go_ready), .add_done(add_done),
    .round_idx(round_idx), .ifmap_base(ifmap_base), .busy(busy),
    .done_valid(done_valid), .done_ready(done_ready)
`ifdef SCHED_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       is_done;
    logic [3:0] round;
    logic [7:0] base;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic       sv;
    logic       ready, bsy, mem;
    logic [4:0] pe;
    logic       add, done;
    logic [3:0] round;
    logic [7:0] base;
  } vec_t;
  vec_t tbl[17];

  logic [NUM_PE-1:0] pend_pe;
  logic              pend_add;
  int                add_xfers;
  bit                auto_mode;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic vec_t mkv(input logic sv, input logic ready, input logic bsy,
                               input logic mem, input logic [4:0] pe, input logic add,
                               input logic done, input int round, input int base);
    vec_t v;
    v.sv = sv; v.ready = ready; v.bsy = bsy; v.mem = mem; v.pe = pe;
    v.add = add; v.done = done; v.round = 4'(round); v.base = 8'(base);
    return v;
  endfunction

  task automatic push_conv();
    for (int r = 0; r < NUM_ROUND; r++)
      exp_q.push_back('{1'b0, 4'(r), 8'(r * IFMAP_W)});
    exp_q.push_back('{1'b1, 4'(NUM_ROUND - 1), 8'((NUM_ROUND - 1) * IFMAP_W)});
  endtask

  task automatic pop_check(input logic is_done);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_unexpected: got %s transfer round=%0d, required none",
               is_done ? "done" : "add_go", round_idx);
    end else begin
      e = exp_q.pop_front();
      check(is_done ? "sb_done_kind" : "sb_add_kind", 32'(is_done), 32'(e.is_done));
      check("sb_round", 32'(round_idx), 32'(e.round));
      check("sb_base", 32'(ifmap_base), 32'(e.base));
      $display("transfer %s round=%0d base=%0d", is_done ? "done  " : "add_go",
               round_idx, ifmap_base);
    end
  endtask

  // Observes the transfers that will happen on the coming rising edge.
  task automatic monitor();
    pend_pe  = '0;
    pend_add = 1'b0;
    if (!reset) begin
      pend_pe  = pe_go_valid & pe_go_ready;
      pend_add = add_go_valid & add_go_ready;
      if (pend_add) begin
        add_xfers++;
        pop_check(1'b0);
      end
      if (done_valid && done_ready) pop_check(1'b1);
    end
  endtask

  // One clock: monitor at the falling edge, return 1 time unit after the
  // rising edge; in auto mode each PE/adder answers one cycle after its go.
  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (auto_mode) begin
      pe_done  = pend_pe;
      add_done = pend_add;
    end
  endtask

  task automatic do_start();
    check("start_ready_idle", 32'(start_ready), 32'd1);
    start_valid = 1'b1;
    cycle();
    start_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n = 0;
    while (busy && n < limit) begin
      cycle();
      n++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_watchdog: got simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b1; start_valid = 1'b0; mem_go_ready = 1'b0; pe_go_ready = '0;
    pe_done = '0; add_go_ready = 1'b0; add_done = 1'b0; done_ready = 1'b0;
    auto_mode = 1'b0; add_xfers = 0; pend_pe = '0; pend_add = 1'b0;

    // All readies and done inputs tied high: start at edge N, mem_go at N+1,
    // pe_go at N+2, add_go at N+4, three rounds, then done and back to IDLE.
    //               sv   rdy  bsy  mem  pe      add  done rnd base
    tbl[0]  = mkv(1'b1, 1'b1, 1'b0, 1'b0, 5'h00, 1'b0, 1'b0, 0, 0);
    tbl[1]  = mkv(1'b0, 1'b0, 1'b1, 1'b1, 5'h00, 1'b0, 1'b0, 0, 0);
    tbl[2]  = mkv(1'b0, 1'b0, 1'b1, 1'b0, 5'h1f, 1'b0, 1'b0, 0, 0);
    tbl[3]  = mkv(1'b0, 1'b0, 1'b1, 1'b0, 5'h00, 1'b0, 1'b0, 0, 0);
    tbl[4]  = mkv(1'b0, 1'b0, 1'b1, 1'b0, 5'h00, 1'b1, 1'b0, 0, 0);
    tbl[5]  = mkv(1'b0, 1'b0, 1'b1, 1'b0, 5'h00, 1'b0, 1'b0, 0, 0);
    tbl[6]  = mkv(1'b0, 1'b0, 1'b1, 1'b0, 5'h1f, 1'b0, 1'b0, 1, 7);
    tbl[7]  = mkv(1'b0, 1'b0, 1'b1, 1'b0, 5'h00, 1'b0, 1'b0, 1, 7);
    tbl[8]  = mkv(1'b0, 1'b0, 1'b1, 1'b0, 5'h00, 1'b1, 1'b0, 1, 7);
    tbl[9]  = mkv(1'b0, 1'b0, 1'b1, 1'b0, 5'h00, 1'b0, 1'b0, 1, 7);
    tbl[10] = mkv(1'b0, 1'b0, 1'b1, 1'b0, 5'h1f, 1'b0, 1'b0, 2, 14);
    tbl[11] = mkv(1'b0, 1'b0, 1'b1, 1'b0, 5'h00, 1'b0, 1'b0, 2, 14);
    tbl[12] = mkv(1'b0, 1'b0, 1'b1, 1'b0, 5'h00, 1'b1, 1'b0, 2, 14);
    tbl[13] = mkv(1'b0, 1'b0, 1'b1, 1'b0, 5'h00, 1'b0, 1'b0, 2, 14);
    tbl[14] = mkv(1'b0, 1'b0, 1'b1, 1'b0, 5'h00, 1'b0, 1'b1, 2, 14);
    tbl[15] = mkv(1'b0, 1'b1, 1'b0, 1'b0, 5'h00, 1'b0, 1'b0, 2, 14);
    tbl[16] = mkv(1'b0, 1'b1, 1'b0, 1'b0, 5'h00, 1'b0, 1'b0, 2, 14);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_start_ready", 32'(start_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valids", 32'({mem_go_valid, pe_go_valid, add_go_valid, done_valid}), 32'd0);
    check("rst_round_base", 32'({round_idx, ifmap_base}), 32'd0);

    // Table run with everything tied high (add_done high in IDLE is ignored)
    mem_go_ready = 1'b1; pe_go_ready = '1; pe_done = '1;
    add_go_ready = 1'b1; add_done = 1'b1; done_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      logic [21:0] act, req;
      start_valid = tbl[i].sv;
      if (tbl[i].sv) push_conv();
      act = {start_ready, busy, mem_go_valid, pe_go_valid, add_go_valid,
             done_valid, round_idx, ifmap_base};
      req = {tbl[i].ready, tbl[i].bsy, tbl[i].mem, tbl[i].pe, tbl[i].add,
             tbl[i].done, tbl[i].round, tbl[i].base};
      check($sformatf("vec%0d", i), 32'(act), 32'(req));
      cycle();
    end
    start_valid = 1'b0;
    check("sb_empty_table", 32'(exp_q.size()), 32'd0);
    pe_done = '0; add_done = 1'b0;
    auto_mode = 1'b1;

    // PE 3 back-pressured for 5 cycles
    pe_go_ready = 5'b10111;
    push_conv();
    do_start();
    cycle();
    check("bp_pe_first", 32'(pe_go_valid), 32'h1f);
    cycle();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bp_pe_hold%0d", k), 32'(pe_go_valid), 32'h08);
      check($sformatf("bp_no_add%0d", k), 32'(add_go_valid), 32'd0);
      cycle();
    end
    pe_go_ready = '1;
    check("bp_pe_hold_last", 32'(pe_go_valid), 32'h08);
    cycle();
    check("bp_wait_pe", 32'({pe_go_valid, add_go_valid, busy}), 32'd1);
    cycle();
    check("bp_add_go", 32'(add_go_valid), 32'd1);
    wait_idle("bp_finish", 200);
    check("sb_empty_bp", 32'(exp_q.size()), 32'd0);

    // Done-mask accumulation with repeats and an early pulse in PE_GO,
    // plus a start request while busy
    auto_mode = 1'b0;
    pe_done = '0; add_done = 1'b0;
    push_conv();
    do_start();
    cycle();
    pe_done = 5'b00001;
    start_valid = 1'b1;
    check("busy_start_ready", 32'(start_ready), 32'd0);
    cycle();
    pe_done = 5'b00100;
    start_valid = 1'b0;
    cycle();
    pe_done = 5'b00000;
    cycle();
    pe_done = 5'b00100;
    cycle();
    pe_done = 5'b00000;
    check("mask_partial_add", 32'(add_go_valid), 32'd0);
    check("mask_partial_mem", 32'({mem_go_valid, pe_go_valid}), 32'd0);
    pe_done = 5'b11010;
    cycle();
    pe_done = '0;
    check("mask_full_add_go", 32'(add_go_valid), 32'd1);
    cycle();
    check("wait_add_entered", 32'(add_go_valid), 32'd0);
    cycle();
    check("wait_add_hold", 32'({round_idx, add_go_valid, pe_go_valid}), 32'd0);
    add_done = 1'b1;
    cycle();
    add_done = 1'b0;
    check("round1_pe_go", 32'(pe_go_valid), 32'h1f);
    check("round1_idx_base", 32'({round_idx, ifmap_base}), 32'({4'd1, 8'd7}));
    auto_mode = 1'b1;
    wait_idle("mask_finish", 200);
    check("sb_empty_mask", 32'(exp_q.size()), 32'd0);

    // add_done pulsed in IDLE is ignored
    auto_mode = 1'b0;
    add_done = 1'b1;
    cycle();
    add_done = 1'b0;
    check("idle_add_done", 32'({busy, start_ready, mem_go_valid}), 32'b010);
    check("idle_round_hold", 32'({round_idx, ifmap_base}), 32'({4'd2, 8'd14}));

    // Reset in WAIT_ADD of round 1 (with add_done high on the same edge)
    auto_mode = 1'b1;
    add_xfers = 0;
    push_conv();
    do_start();
    for (int n = 0; n < 100 && add_xfers < 2; n++) cycle();
    check("abort_reach_round1", 32'(add_xfers), 32'd2);
    check("abort_round_idx", 32'(round_idx), 32'd1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    exp_q.delete();
    check("abort_idle", 32'({busy, start_ready, done_valid}), 32'b010);
    check("abort_round_base", 32'({round_idx, ifmap_base}), 32'd0);
    repeat (3) cycle();
    check("abort_no_done", 32'(done_valid), 32'd0);
    push_conv();
    do_start();
    wait_idle("abort_rerun", 200);
    check("sb_empty_abort", 32'(exp_q.size()), 32'd0);

`ifdef SCHED_TIMEOUT_EN
    // PE 4 never reports: watchdog ends the convolution after TMO cycles
    auto_mode = 1'b0;
    pe_done = '0; add_done = 1'b0;
    exp_q.push_back('{1'b1, 4'd0, 8'd0});
    do_start();
    cycle();
    cycle();
    pe_done = 5'b01111;
    for (int k = 1; k <= TMO; k++) begin
      check($sformatf("tmo_wait%0d", k), 32'({done_valid, timeout}), 32'd0);
      cycle();
      pe_done = '0;
    end
    check("tmo_done", 32'({done_valid, timeout}), 32'b11);
    cycle();
    check("tmo_sticky", 32'({busy, timeout}), 32'b01);
    push_conv();
    auto_mode = 1'b1;
    do_start();
    check("tmo_cleared", 32'(timeout), 32'd0);
    wait_idle("tmo_rerun", 200);
    check("sb_empty_tmo", 32'(exp_q.size()), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
